mole_round_scheduler: RTL and testbench

Round sequencer for the whack-a-mole game. It owns the single shared countdown/count-up timer and time-multiplexes it between the "mole shown" window and the inter-mole gap. It picks which mole LED lights each round from the RNG value and scores hits and misses. It sits between the RNG, the button synchronisers, the shared timer and the LED/score logic.

---
 rtl/mole_round_scheduler_pkg.sv | 29 ++
 rtl/mole_round_scheduler_picker.sv | 33 +++
 rtl/mole_round_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mole_round_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_round_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mole_pkg
// Description : Shared types and constants for the whack-a-mole round
//               scheduler and its mole picker.
// Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    // Scheduler states; values are fixed so the encoding is stable.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PICK     = 3'd1,
        ST_LOAD_ON  = 3'd2,
        ST_SHOW     = 3'd3,
        ST_LOAD_GAP = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Difficulty shifts the show window: window = ON_BASE >> difficulty.
    typedef logic [1:0] difficulty_t;

    // Direction encoding for the shared timer's timer_up input.
    localparam logic TIMER_MODE_DOWN = 1'b0;
    localparam logic TIMER_MODE_UP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mole_round_scheduler_picker.sv
`default_nettype none
// ============================================================================
// Module      : mole_picker
// Description : Chooses the next mole from the RNG value, bumping to the next
//               mole (mod N) when the candidate repeats the previous one.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_picker
    import mole_pkg::*;
#(
    parameter int N_MOLES = 4
) (
    input  logic [7:0]                 rng_value,
    input  logic [$clog2(N_MOLES)-1:0] prev_mole,
    output logic [$clog2(N_MOLES)-1:0] cur_mole
);

    localparam int c_idx_w = $clog2(N_MOLES);

    logic [c_idx_w-1:0] w_cand;
    logic               w_unused_rng;

    // Only the low bits select a mole; the rest of the RNG word is unused.
    assign w_unused_rng = ^rng_value[7:c_idx_w];

    // N_MOLES is a power of two, so the +1 bump wraps naturally.
    always_comb begin
        w_cand   = rng_value[c_idx_w-1:0];
        cur_mole = (w_cand == prev_mole) ? (w_cand + c_idx_w'(1)) : w_cand;
    end

endmodule
`default_nettype wire

// File: rtl/mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_round_scheduler
// Description : Whack-a-mole round sequencer. Time-multiplexes one shared
//               timer between the show window and the inter-mole gap, picks
//               the lit mole, and scores hits, misses and wrong hits.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_round_scheduler
    import mole_pkg::*;
#(
    parameter int N_MOLES = 4,
    parameter int TIMER_W = 11,
    parameter int ON_BASE = 1000,
    parameter int GAP_LEN = 300,
    parameter int ROUNDS  = 20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   difficulty,
    input  logic [7:0]                   rng_value,
    input  logic [N_MOLES-1:0]           hit,
    input  logic [TIMER_W-1:0]           timer_value,
    output logic                         timer_reset,
    output logic                         timer_up,
    output logic                         timer_enable,
    output logic [TIMER_W-1:0]           timer_load,
    output logic [N_MOLES-1:0]           led,
    output logic                         score_inc,
    output logic                         miss,
    output logic                         wrong_hit,
    output logic [$clog2(ROUNDS+1)-1:0]  round_count,
    output logic                         done
);

    localparam int                 c_idx_w   = $clog2(N_MOLES);
    localparam int                 c_rc_w    = $clog2(ROUNDS+1);
    localparam logic [TIMER_W-1:0] c_on_base = TIMER_W'(ON_BASE);
    localparam logic [TIMER_W-1:0] c_gap_end = TIMER_W'(GAP_LEN);
    localparam logic [c_rc_w-1:0]  c_rounds  = c_rc_w'(ROUNDS);

    state_t              r_state;
    difficulty_t         r_diff;
    logic [c_idx_w-1:0]  r_cur_mole;
    logic [c_idx_w-1:0]  r_prev_mole;
    logic [c_rc_w-1:0]   r_round_count;
    logic                r_score_inc;
    logic                r_miss;
    logic                r_wrong_hit;
    logic [c_idx_w-1:0]  w_pick;
    logic [N_MOLES-1:0]  w_onehot;
    logic                w_hit_cur;
    logic                w_hit_other;

    mole_picker #(
        .N_MOLES (N_MOLES)
    ) u_picker (
        .rng_value (rng_value),
        .prev_mole (r_prev_mole),
        .cur_mole  (w_pick)
    );

    // Decode the lit mole and classify this cycle's button presses.
    always_comb begin
        w_onehot    = {{(N_MOLES-1){1'b0}}, 1'b1} << r_cur_mole;
        w_hit_cur   = hit[r_cur_mole];
        w_hit_other = |(hit & ~w_onehot);
    end

    // Round sequencing, mole bookkeeping and registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_diff        <= '0;
            r_cur_mole    <= '0;
            r_prev_mole   <= '0;
            r_round_count <= '0;
            r_score_inc   <= 1'b0;
            r_miss        <= 1'b0;
            r_wrong_hit   <= 1'b0;
        end else begin
            r_score_inc <= 1'b0;
            r_miss      <= 1'b0;
            r_wrong_hit <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // A fresh game forgets the previous mole so mole 0 is never first.
                        r_diff        <= difficulty;
                        r_round_count <= '0;
                        r_prev_mole   <= '0;
                        r_state       <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    r_cur_mole <= w_pick;
                    r_state    <= ST_LOAD_ON;
                end
                ST_LOAD_ON: begin
                    r_round_count <= r_round_count + c_rc_w'(1);
                    r_state       <= ST_SHOW;
                end
                ST_SHOW: begin
                    // A correct hit outranks a simultaneous expiry.
                    if (w_hit_cur) begin
                        r_score_inc <= 1'b1;
                        r_state     <= ST_LOAD_GAP;
                    end else if (timer_value == '0) begin
                        r_miss  <= 1'b1;
                        r_state <= ST_LOAD_GAP;
                    end
                    if (w_hit_other) begin
                        r_wrong_hit <= 1'b1;
                    end
                end
                ST_LOAD_GAP: begin
                    r_prev_mole <= r_cur_mole;
                    r_state     <= ST_GAP;
                end
                ST_GAP: begin
                    if (timer_value == c_gap_end) begin
                        r_state <= (r_round_count == c_rounds) ? ST_DONE : ST_PICK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the timer controls, LEDs and done flag from state.
    always_comb begin
        timer_reset  = 1'b0;
        timer_up     = TIMER_MODE_DOWN;
        timer_enable = 1'b0;
        timer_load   = '0;
        led          = '0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                timer_reset = 1'b1;
            end
            ST_LOAD_ON: begin
                timer_reset = 1'b1;
                timer_load  = c_on_base >> r_diff;
            end
            ST_SHOW: begin
                timer_enable = 1'b1;
                led          = w_onehot;
            end
            ST_LOAD_GAP: begin
                timer_reset = 1'b1;
                timer_up    = TIMER_MODE_UP;
            end
            ST_GAP: begin
                timer_enable = 1'b1;
                timer_up     = TIMER_MODE_UP;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                timer_reset = 1'b0;
            end
        endcase
    end

    assign score_inc   = r_score_inc;
    assign miss        = r_miss;
    assign wrong_hit   = r_wrong_hit;
    assign round_count = r_round_count;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_round_scheduler
// Description : Scoreboard bench for mole_round_scheduler with a model of the
//               shared timer (N=4, ON_BASE=8, GAP_LEN=300, ROUNDS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_round_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  difficulty;
    logic [7:0]  rng_value;
    logic [3:0]  hit;
    logic [10:0] timer_value = '0;
    logic        timer_reset;
    logic        timer_up;
    logic        timer_enable;
    logic [10:0] timer_load;
    logic [3:0]  led;
    logic        score_inc;
    logic        miss;
    logic        wrong_hit;
    logic [1:0]  round_count;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;

    // Observed/expected output event: {led, score_inc, miss, wrong_hit, done, round_count}
    logic [9:0] exp_q[$];
    logic       mon_en    = 1'b0;
    logic [3:0] prev_led  = '0;
    logic       prev_done = 1'b0;

    mole_round_scheduler #(
        .N_MOLES (4),
        .TIMER_W (11),
        .ON_BASE (8),
        .GAP_LEN (300),
        .ROUNDS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .difficulty   (difficulty),
        .rng_value    (rng_value),
        .hit          (hit),
        .timer_value  (timer_value),
        .timer_reset  (timer_reset),
        .timer_up     (timer_up),
        .timer_enable (timer_enable),
        .timer_load   (timer_load),
        .led          (led),
        .score_inc    (score_inc),
        .miss         (miss),
        .wrong_hit    (wrong_hit),
        .round_count  (round_count),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared timer model: load wins over count.
    always @(posedge clk) begin
        if (timer_reset)
            timer_value <= timer_load;
        else if (timer_enable)
            timer_value <= timer_up ? timer_value + 11'd1 : timer_value - 11'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v)
            n_pass++;
        else
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp_v);
    endtask

    function automatic logic [9:0] ev(input logic [3:0] l, input logic s, input logic m,
                                      input logic w, input logic d, input logic [1:0] r);
        return {l, s, m, w, d, r};
    endfunction

    // Monitor: any pulse, LED change or done rising is an output event.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [9:0] obs;
            obs = {led, score_inc, miss, wrong_hit, done, round_count};
            if (score_inc || miss || wrong_hit || (led != prev_led) || (done && !prev_done)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: actual=%0h required=none", obs);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("scoreboard_event", {22'd0, obs}, {22'd0, e});
                end
            end
            prev_led  = led;
            prev_done = done;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] d);
        start      = 1'b1;
        difficulty = d;
        cyc();
        start      = 1'b0;
    endtask

    task automatic wait_led(input string name, input int max);
        int n = 0;
        while (led == 4'd0 && n < max) begin
            cyc();
            n++;
        end
        check(name, {31'd0, led != 4'd0}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done && n < max) begin
            cyc();
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; difficulty = 2'd0; rng_value = 8'd0; hit = 4'd0;
        repeat (3) cyc();
        reset = 1'b0;
        check("rst_timer_reset", {31'd0, timer_reset}, 32'd1);
        check("rst_timer_load", {21'd0, timer_load}, 32'd0);
        check("rst_up_en", {30'd0, timer_up, timer_enable}, 32'd0);
        check("rst_led_pulses", {25'd0, led, score_inc, miss, wrong_hit}, 32'd0);
        check("rst_round_done", {29'd0, round_count, done}, 32'd0);
        mon_en = 1'b1;
        cyc();

        // Game A round 1: rng 0x05 -> mole 1, no hit -> miss.
        rng_value = 8'h05;
        exp_q.push_back(ev(4'b0010, 0, 0, 0, 0, 2'd1));
        exp_q.push_back(ev(4'b0000, 0, 1, 0, 0, 2'd1));
        pulse_start(2'd0);                       // now in PICK
        cyc();                                   // LOAD_ON
        check("load_on_value", {21'd0, timer_load}, 32'd8);
        check("load_on_ctrl", {30'd0, timer_reset, timer_enable}, 32'b10);
        cyc();                                   // third cycle after start: SHOW
        check("led_latency", {28'd0, led}, 32'b0010);
        n = 0;
        while (led != 4'd0 && n < 50) begin n++; cyc(); end
        check("show_len_diff0", n, 32'd9);
        rng_value = 8'h07;
        exp_q.push_back(ev(4'b1000, 0, 0, 0, 0, 2'd2));
        exp_q.push_back(ev(4'b0000, 1, 0, 0, 0, 2'd2));
        exp_q.push_back(ev(4'b0000, 0, 0, 0, 1, 2'd2));
        cyc();                                   // first GAP cycle
        n = 0;
        while (timer_enable && timer_up && led == 4'd0 && n < 1000) begin n++; cyc(); end
        check("gap_len_up", n, 32'd301);

        // Game A round 2: rng 0x07 -> mole 3, hit exactly at expiry.
        wait_led("wait_led_a2", 20);
        check("mole3_led", {28'd0, led}, 32'b1000);
        n = 0;
        while (timer_value != 11'd0 && n < 50) begin n++; cyc(); end
        hit = 4'b1000;
        cyc();
        hit = 4'b0000;
        check("tie_score_miss", {30'd0, score_inc, miss}, 32'b10);
        wait_done("wait_done_a", 1000);
        check("done_rounds", {30'd0, round_count}, 32'd2);
        check("done_timer_idle", {30'd0, timer_enable, timer_reset}, 32'd0);

        // Game B from DONE: rng 0x04 bumps from mole 0 to mole 1.
        rng_value = 8'h04;
        exp_q.push_back(ev(4'b0010, 0, 0, 0, 0, 2'd1));
        exp_q.push_back(ev(4'b0000, 1, 0, 0, 0, 2'd1));
        pulse_start(2'd0);
        wait_led("wait_led_b1", 20);
        check("bump_led", {28'd0, led}, 32'b0010);
        hit = 4'b0010;
        cyc();
        hit = 4'b0000;
        rng_value = 8'h06;
        exp_q.push_back(ev(4'b0100, 0, 0, 0, 0, 2'd2));
        exp_q.push_back(ev(4'b0100, 0, 0, 1, 0, 2'd2));
        exp_q.push_back(ev(4'b0000, 1, 0, 0, 0, 2'd2));
        exp_q.push_back(ev(4'b0000, 0, 0, 0, 1, 2'd2));
        wait_led("wait_led_b2", 400);
        hit = 4'b0001;
        cyc();
        hit = 4'b0000;
        check("wrong_hit_led", {27'd0, wrong_hit, led}, {27'd0, 1'b1, 4'b0100});
        hit = 4'b0100;
        cyc();
        hit = 4'b0000;
        repeat (3) cyc();
        hit = 4'b0001;
        cyc();
        hit = 4'b0000;
        check("gap_hit_ignored", {25'd0, led, score_inc, miss, wrong_hit}, 32'd0);
        wait_done("wait_done_b", 1000);

        // Game C: difficulty 3, reset in the middle of SHOW.
        rng_value = 8'h05;
        exp_q.push_back(ev(4'b0010, 0, 0, 0, 0, 2'd1));
        exp_q.push_back(ev(4'b0000, 0, 0, 0, 0, 2'd0));
        pulse_start(2'd3);
        cyc();
        check("load_on_diff3", {21'd0, timer_load}, 32'd1);
        cyc();
        check("restart_round1_led", {28'd0, led}, 32'b0010);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midshow_rst_led_treset", {27'd0, led, timer_reset}, {27'd0, 4'b0000, 1'b1});
        check("midshow_rst_round", {29'd0, round_count, done}, 32'd0);
        exp_q.push_back(ev(4'b0010, 0, 0, 0, 0, 2'd1));
        exp_q.push_back(ev(4'b0000, 0, 1, 0, 0, 2'd1));
        pulse_start(2'd2);
        cyc();
        check("load_on_diff2", {21'd0, timer_load}, 32'd2);
        cyc();
        n = 0;
        while (led != 4'd0 && n < 50) begin n++; cyc(); end
        check("show_len_diff2", n, 32'd3);
        repeat (3) cyc();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
